// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LS arbiter for the single memory port with bus timeout

module mux_addr #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

module mem_port_arbiter #(
   parameter int DATABUS_SIZE   = 32,
   parameter int ADDR_BUS_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      if_req,
   input  logic [ADDR_BUS_WIDTH-1:0] if_addr,
   output logic [DATABUS_SIZE-1:0]   if_rdata,
   output logic                      if_done,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [ADDR_BUS_WIDTH-1:0] ls_addr,
   input  logic [DATABUS_SIZE-1:0]   ls_wdata,
   output logic [DATABUS_SIZE-1:0]   ls_rdata,
   output logic                      ls_done,
   output logic                      bus_err,
   output logic                      addr_sel,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
   output logic [DATABUS_SIZE-1:0]   mem_wdata,
   input  logic [DATABUS_SIZE-1:0]   mem_rdata,
   input  logic                      mem_ready
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS, RESP} state_t;

   state_t          state;
   state_t          next_state;
   logic            last_grant;   // 0 = IF, 1 = LS
   logic            err_q;
   logic [CW-1:0]   cnt;
   logic            timeout;

   // addr_sel also identifies the done target while in RESP
   assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign mem_wdata = ls_wdata;

   mux_addr #(.WIDTH(ADDR_BUS_WIDTH)) u_mux_addr (
      .in0 (if_addr),
      .in1 (ls_addr),
      .sel (addr_sel),
      .out (mem_addr)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // next state: round-robin pick in IDLE, leave GNT on ready or timeout
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (if_req && ls_req) next_state = last_grant ? GNT_IF : GNT_LS;
            else if (if_req)      next_state = GNT_IF;
            else if (ls_req)      next_state = GNT_LS;
         end
         GNT_IF, GNT_LS: begin
            if (mem_ready || timeout) next_state = RESP;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // outputs decoded from state; done goes to the requester held in addr_sel
   always_comb begin
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      if_done = 1'b0;
      ls_done = 1'b0;
      bus_err = 1'b0;
      case (state)
         GNT_IF: mem_en = 1'b1;
         GNT_LS: begin
            mem_en = 1'b1;
            mem_we = ls_we;
         end
         RESP: begin
            if_done = !addr_sel;
            ls_done = addr_sel;
            bus_err = err_q;
         end
         default: ;
      endcase
   end

   // grant bookkeeping, timeout counter and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         addr_sel   <= 1'b0;
         err_q      <= 1'b0;
         cnt        <= '0;
         if_rdata   <= '0;
         ls_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (next_state == GNT_IF || next_state == GNT_LS) begin
                  last_grant <= (next_state == GNT_LS);
                  addr_sel   <= (next_state == GNT_LS);
                  cnt        <= '0;
               end
            end
            GNT_IF, GNT_LS: begin
               if (mem_ready) begin
                  err_q <= 1'b0;
                  if (state == GNT_IF) if_rdata <= mem_rdata;
                  else if (!ls_we)     ls_rdata <= mem_rdata;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (state == GNT_IF) if_rdata <= '0;
                  else                 ls_rdata <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [15:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        ls_req;
   logic        ls_we;
   logic [15:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_done;
   logic        bus_err;
   logic        addr_sel;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_checks = 0;
   int n_pass   = 0;
   int waited;
   int n;

   logic if_busy;
   logic ls_busy;

   mem_port_arbiter #(
      .DATABUS_SIZE   (32),
      .ADDR_BUS_WIDTH (16),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_rdata  (ls_rdata),
      .ls_done   (ls_done),
      .bus_err   (bus_err),
      .addr_sel  (addr_sel),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   // requesters must hold req from grant until their done cycle ends
   always @(posedge clk) begin
      if (reset) begin
         if_busy <= 1'b0;
         ls_busy <= 1'b0;
      end else begin
         if (if_busy && !if_req) $error("if_req dropped before if_done");
         if (ls_busy && !ls_req) $error("ls_req dropped before ls_done");
         if (if_done)                   if_busy <= 1'b0;
         else if (mem_en && !addr_sel)  if_busy <= 1'b1;
         if (ls_done)                   ls_busy <= 1'b0;
         else if (mem_en && addr_sel)   ls_busy <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ends at the negedge of the first cycle with mem_en high (bounded)
   task automatic wait_en(output int w);
      w = 0;
      @(negedge clk);
      while (!mem_en && w < 8) begin
         @(negedge clk);
         w++;
      end
      check("wait_mem_en", {31'd0, mem_en}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
      ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_if_done",  {31'd0, if_done},  32'd0);
      check("rst_ls_done",  {31'd0, ls_done},  32'd0);
      check("rst_bus_err",  {31'd0, bus_err},  32'd0);
      check("rst_mem_en",   {31'd0, mem_en},   32'd0);
      check("rst_mem_we",   {31'd0, mem_we},   32'd0);
      check("rst_addr_sel", {31'd0, addr_sel}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_ls_rdata", ls_rdata, 32'd0);

      // LS store, ready in the 3rd GNT cycle
      step();
      reset = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 32'h12345678;
      @(negedge clk);
      check("st_req_cycle_en", {31'd0, mem_en}, 32'd0);
      step(); @(negedge clk);
      check("st_mem_en",    {31'd0, mem_en},   32'd1);
      check("st_mem_we",    {31'd0, mem_we},   32'd1);
      check("st_addr_sel",  {31'd0, addr_sel}, 32'd1);
      check("st_mem_addr",  {16'd0, mem_addr}, 32'h0200);
      check("st_mem_wdata", mem_wdata, 32'h12345678);
      step(); @(negedge clk);
      check("st_gnt2_en", {31'd0, mem_en}, 32'd1);
      step(); mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("st_ls_done",  {31'd0, ls_done}, 32'd1);
      check("st_bus_err",  {31'd0, bus_err}, 32'd0);
      check("st_if_done",  {31'd0, if_done}, 32'd0);
      check("st_ls_rdata", ls_rdata, 32'd0);
      check("st_resp_en",  {31'd0, mem_en},  32'd0);
      step(); ls_req = 1'b0; ls_we = 1'b0;
      @(negedge clk);
      check("st_done_once", {31'd0, ls_done},  32'd0);
      check("st_sel_hold",  {31'd0, addr_sel}, 32'd1);
      check("st_we_idle",   {31'd0, mem_we},   32'd0);

      // IF-only load, ready one cycle after mem_en rises
      step(); if_req = 1'b1; if_addr = 16'h0010;
      step(); @(negedge clk);
      check("if_mem_en",   {31'd0, mem_en},   32'd1);
      check("if_mem_we",   {31'd0, mem_we},   32'd0);
      check("if_addr_sel", {31'd0, addr_sel}, 32'd0);
      check("if_mem_addr", {16'd0, mem_addr}, 32'h0010);
      step(); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("if_done",    {31'd0, if_done}, 32'd1);
      check("if_rdata",   if_rdata, 32'hDEADBEEF);
      check("if_ls_done", {31'd0, ls_done}, 32'd0);
      step(); if_req = 1'b0;
      @(negedge clk);
      check("if_done_once", {31'd0, if_done}, 32'd0);

      // contention after reset: IF, LS, IF, LS
      step(); reset = 1'b1;
      step(); reset = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
      if_addr = 16'h0040; ls_addr = 16'h0300;
      for (int i = 0; i < 4; i++) begin
         wait_en(waited);
         check($sformatf("rr_grant%0d", i), {31'd0, addr_sel}, i % 2);
         mem_ready = 1'b1; mem_rdata = 32'hA0000000 + i;
         step(); mem_ready = 1'b0;
         @(negedge clk);
         check($sformatf("rr_if_done%0d", i), {31'd0, if_done}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_ls_done%0d", i), {31'd0, ls_done}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i == 3) begin
            step(); if_req = 1'b0; ls_req = 1'b0;
         end
         @(negedge clk);
         check($sformatf("rr_single%0d", i), {30'd0, if_done, ls_done}, 32'd0);
      end
      check("rr_if_rdata", if_rdata, 32'hA0000002);
      check("rr_ls_rdata", ls_rdata, 32'hA0000003);

      // timeout: mem_ready never comes
      step(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0400;
      wait_en(waited);
      n = 1;
      @(negedge clk);
      while (mem_en && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("to_en_cycles", n, 32'd15);
      check("to_ls_done",   {31'd0, ls_done}, 32'd1);
      check("to_bus_err",   {31'd0, bus_err}, 32'd1);
      check("to_ls_rdata",  ls_rdata, 32'd0);
      check("to_if_done",   {31'd0, if_done}, 32'd0);
      step(); ls_req = 1'b0;
      @(negedge clk);
      check("to_err_clear", {31'd0, bus_err}, 32'd0);

      // ready arrives in the 15th GNT cycle: no error
      step(); ls_req = 1'b1;
      wait_en(waited);
      repeat (14) @(negedge clk);
      check("to15_en", {31'd0, mem_en}, 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("to15_ls_done",  {31'd0, ls_done}, 32'd1);
      check("to15_bus_err",  {31'd0, bus_err}, 32'd0);
      check("to15_ls_rdata", ls_rdata, 32'h55AA55AA);
      step(); ls_req = 1'b0;

      // reset during the 2nd GNT_LS cycle
      step(); ls_req = 1'b1; ls_addr = 16'h0500;
      wait_en(waited);
      step(); reset = 1'b1; ls_req = 1'b0;
      @(negedge clk);
      step(); reset = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0044;
      @(negedge clk);
      check("rm_mem_en", {31'd0, mem_en},  32'd0);
      check("rm_no_done", {31'd0, ls_done}, 32'd0);
      step(); @(negedge clk);
      check("rm_if_first_en",  {31'd0, mem_en},   32'd1);
      check("rm_if_first_sel", {31'd0, addr_sel}, 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h11112222;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("rm_if_done",  {31'd0, if_done}, 32'd1);
      check("rm_if_rdata", if_rdata, 32'h11112222);
      step(); if_req = 1'b0;
      wait_en(waited);
      check("rm_ls_sel", {31'd0, addr_sel}, 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h33334444;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("rm_ls_done",  {31'd0, ls_done}, 32'd1);
      check("rm_ls_rdata", ls_rdata, 32'h33334444);
      step(); ls_req = 1'b0;

      // back-to-back IF with if_req held across done
      step(); if_req = 1'b1; if_addr = 16'h0080;
      wait_en(waited);
      mem_ready = 1'b1; mem_rdata = 32'h0BAD0001;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("b2b_done1", {31'd0, if_done}, 32'd1);
      n = 0;
      while (!mem_en && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("b2b_gap", n, 32'd2);
      check("b2b_sel", {31'd0, addr_sel}, 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'h0BAD0002;
      step(); mem_ready = 1'b0;
      @(negedge clk);
      check("b2b_done2",  {31'd0, if_done}, 32'd1);
      check("b2b_rdata2", if_rdata, 32'h0BAD0002);
      step(); if_req = 1'b0;
      @(negedge clk);
      check("b2b_done_once", {31'd0, if_done}, 32'd0);
      step(); @(negedge clk);
      check("b2b_idle_en", {31'd0, mem_en}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
